// File: rtl/phy_rx_sync_ctrl.sv
// Comma-based receive symbol sync: hunts LOCK_CNT commas, forwards data bytes in ACTIVE, flags idle; SYNC_STATS_EN adds a lock-loss counter.
// Latency: one cycle from sampled byte to data_out/valid_out; state/active_out/IDLE_out update one cycle after the deciding sample.
// Backpressure: none; the deserializer cannot be stalled, so a byte arriving in HUNT/RESYNC or with resync_req is dropped.
module phy_rx_sync_ctrl #(
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 4,
    parameter logic [7:0]  COMMA_SYM = 8'hBC,
    parameter logic [7:0]  IDLE_SYM  = 8'h7C
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       resync_req,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active_out,
    output logic       IDLE_out,
    output logic [1:0] sync_state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        ACTIVE = 2'b01,
        RESYNC = 2'b10
    } sync_state_t;

    localparam logic [4:0] LOCK_TH = 5'(LOCK_CNT);
    localparam logic [4:0] LOSS_TH = 5'(LOSS_CNT);

    sync_state_t state, state_nxt;
    logic [3:0]  comma_cnt, comma_nxt;
    logic [3:0]  gap_cnt, gap_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        idle_nxt;
    logic [4:0]  comma_inc;
    logic [4:0]  gap_inc;
    logic [3:0]  comma_sat;
    logic [3:0]  gap_sat;

    // 5-bit increments so the threshold compare cannot be fooled by a wrap.
    assign comma_inc = {1'b0, comma_cnt} + 5'd1;
    assign gap_inc   = {1'b0, gap_cnt} + 5'd1;
    assign comma_sat = (comma_cnt == 4'hF) ? 4'hF : comma_cnt + 4'd1;
    assign gap_sat   = (gap_cnt == 4'hF) ? 4'hF : gap_cnt + 4'd1;

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= HUNT;
            comma_cnt <= 4'd0;
            gap_cnt   <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            IDLE_out  <= 1'b0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_nxt;
            gap_cnt   <= gap_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            IDLE_out  <= idle_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        comma_nxt = comma_cnt;
        gap_nxt   = gap_cnt;
        data_nxt  = data_out;
        valid_nxt = 1'b0;
        idle_nxt  = IDLE_out;
        case (state)
            HUNT: begin
                idle_nxt = 1'b0;
                gap_nxt  = 4'd0;
                if (valid_in) begin
                    if (data_in == COMMA_SYM) begin
                        if (comma_inc >= LOCK_TH) begin
                            state_nxt = ACTIVE;
                            comma_nxt = 4'd0;
                        end else begin
                            comma_nxt = comma_sat;
                        end
                    end else begin
                        comma_nxt = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                comma_nxt = 4'd0;
                // An explicit resync wins over whatever byte shares its cycle.
                if (resync_req) begin
                    state_nxt = RESYNC;
                    gap_nxt   = 4'd0;
                    idle_nxt  = 1'b0;
                end else if (valid_in) begin
                    gap_nxt = 4'd0;
                    if (data_in == IDLE_SYM) begin
                        idle_nxt = 1'b1;
                    end else if (data_in != COMMA_SYM) begin
                        data_nxt  = data_in;
                        valid_nxt = 1'b1;
                        idle_nxt  = 1'b0;
                    end
                end else if (gap_inc >= LOSS_TH) begin
                    state_nxt = RESYNC;
                    gap_nxt   = 4'd0;
                    idle_nxt  = 1'b0;
                end else begin
                    gap_nxt = gap_sat;
                end
            end
            RESYNC: begin
                state_nxt = HUNT;
                comma_nxt = 4'd0;
                gap_nxt   = 4'd0;
                idle_nxt  = 1'b0;
            end
            default: begin
                state_nxt = HUNT;
                comma_nxt = 4'd0;
                gap_nxt   = 4'd0;
                idle_nxt  = 1'b0;
            end
        endcase
    end

    assign active_out = (state == ACTIVE);
    assign sync_state = state;

`ifdef SYNC_STATS_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    assign loss_evt = (state == ACTIVE) && (state_nxt == RESYNC);

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            loss_q <= 8'h00;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

    a_state_legal : assert property (@(posedge clk_4f) disable iff (!reset_L)
        sync_state != 2'b11);

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Bench for phy_rx_sync_ctrl: vector table through a scoreboard queue, then
// lock-loss counter saturation and mid-cycle asynchronous reset sequences.
module tb_phy_rx_sync_ctrl;

    localparam logic [7:0] BC = 8'hBC;
    localparam logic [7:0] IC = 8'h7C;
`ifdef SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk_4f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       resync_req = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic       IDLE_out;
    logic [1:0] sync_state;
    logic [7:0] lock_loss_cnt;

    phy_rx_sync_ctrl #(
        .LOCK_CNT (4),
        .LOSS_CNT (4),
        .COMMA_SYM(8'hBC),
        .IDLE_SYM (8'h7C)
    ) dut (
        .clk_4f       (clk_4f),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .resync_req   (resync_req),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .active_out   (active_out),
        .IDLE_out     (IDLE_out),
        .sync_state   (sync_state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       evo;
        logic [7:0] edo;
        logic       eidle;
        logic [1:0] est;
        int         ellc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [7:0] llc_of(input int n);
        int m;
        m = (n > 255) ? 255 : n;
        return STATS ? 8'(m) : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic evo, input logic [7:0] edo,
                              input logic eidle, input logic [1:0] est, input int ellc);
        chk({tag, " valid_out"},     32'(valid_out),     32'(evo));
        chk({tag, " data_out"},      32'(data_out),      32'(edo));
        chk({tag, " IDLE_out"},      32'(IDLE_out),      32'(eidle));
        chk({tag, " sync_state"},    32'(sync_state),    32'(est));
        chk({tag, " active_out"},    32'(active_out),    32'(est == 2'b01));
        chk({tag, " lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(llc_of(ellc)));
    endtask

    // Drive one vector at the falling edge, score the outputs just after the rising edge.
    task automatic step(input vec_t t, input int idx);
        vec_t e;
        valid_in   = t.v;
        data_in    = t.d;
        resync_req = t.r;
        sb.push_back(t);
        @(posedge clk_4f);
        #1;
        e = sb.pop_front();
        check_outs($sformatf("vec%0d", idx), e.evo, e.edo, e.eidle, e.est, e.ellc);
        @(negedge clk_4f);
    endtask

    task automatic drv(input logic v, input logic [7:0] d, input logic r);
        valid_in   = v;
        data_in    = d;
        resync_req = r;
        @(posedge clk_4f);
        @(negedge clk_4f);
    endtask

    initial begin
        // Broken comma run with a hold cycle, then lock on the 4th consecutive comma.
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 0});
        // Idle / data / comma / idle in ACTIVE.
        tbl.push_back('{1'b1, IC,    1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 0});
        tbl.push_back('{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'hA5, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b1, IC,    1'b0, 1'b0, 8'hA5, 1'b1, 2'b01, 0});
        // Three-cycle gap recovered by a data byte, then a four-cycle gap.
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 2'b01, 0});
        tbl.push_back('{1'b1, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 2'b10, 1});
        // Comma during RESYNC is ignored; the next four relock.
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 1});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 1});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 1});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 1});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b01, 1});
        // resync_req collides with a data byte; later requests in RESYNC/HUNT ignored.
        tbl.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 8'h12, 1'b0, 2'b10, 2});
        tbl.push_back('{1'b1, 8'h44, 1'b1, 1'b0, 8'h12, 1'b0, 2'b00, 2});
        tbl.push_back('{1'b1, BC,    1'b1, 1'b0, 8'h12, 1'b0, 2'b00, 2});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 2});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 2});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b0, 2'b01, 2});
        // Comma keeps the idle flag; a resync clears it.
        tbl.push_back('{1'b1, IC,    1'b0, 1'b0, 8'h12, 1'b1, 2'b01, 2});
        tbl.push_back('{1'b1, BC,    1'b0, 1'b0, 8'h12, 1'b1, 2'b01, 2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0, 2'b10, 3});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b0, 2'b00, 3});

        #2;
        check_outs("reset", 1'b0, 8'h00, 1'b0, 2'b00, 0);
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Lock/resync enough times to push the loss counter past 255.
        for (int k = 0; k < 253; k++) begin
            for (int j = 0; j < 4; j++) drv(1'b1, BC, 1'b0);
            drv(1'b0, 8'h00, 1'b1);
            drv(1'b0, 8'h00, 1'b0);
        end
        chk("sat lock_loss_cnt", 32'(lock_loss_cnt), 32'(llc_of(256)));
        chk("sat sync_state", 32'(sync_state), 32'(2'b00));

        // Lock, forward one byte, then hit reset between clock edges.
        for (int j = 0; j < 4; j++) drv(1'b1, BC, 1'b0);
        valid_in = 1'b1;
        data_in  = 8'hA5;
        @(posedge clk_4f);
        #1;
        check_outs("pre_rst", 1'b1, 8'hA5, 1'b0, 2'b01, 256);
        data_in = BC;
        #2;
        reset_L = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 8'h00, 1'b0, 2'b00, 0);
        @(posedge clk_4f);
        #1;
        check_outs("rst_held", 1'b0, 8'h00, 1'b0, 2'b00, 0);
        @(negedge clk_4f);
        reset_L = 1'b1;
        for (int j = 0; j < 3; j++) step('{1'b1, BC, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 0}, 100 + j);
        step('{1'b1, BC, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 0}, 103);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
